// File: rtl/sort_stream_collector.sv
// Captures fixed-length frames from the sorter output stream, checks ordering, sums
// samples and publishes each completed frame into a ping-pong buffer for readback.
module sort_stream_collector #(
  parameter int N_ELEM = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int AW    = $clog2(N_ELEM),
  localparam int SW    = DATA_W + AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              sort_err,
  output logic [AW-1:0]     err_idx,
  output logic [SW-1:0]     frame_sum,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_ELEM - 1);
  localparam logic [AW:0]   N_LIM    = (AW+1)'(N_ELEM);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t            state;
  logic [DATA_W-1:0] bank [2][N_ELEM];
  logic              wbank;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     err_pos;
  logic [DATA_W-1:0] prev;
  logic [SW-1:0]     sum;
  logic              err;

  logic              last;
  logic              desc;
  logic              rd_in_range;
  logic [SW-1:0]     sum_next;

  assign last        = (idx == LAST_IDX);
  assign desc        = (s_data < prev);
  assign rd_in_range = ({1'b0, rd_addr} < N_LIM);
  assign sum_next    = sum + SW'(s_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wbank       <= 1'b0;
      idx         <= '0;
      err_pos     <= '0;
      prev        <= '0;
      sum         <= '0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      sort_err    <= 1'b0;
      err_idx     <= '0;
      frame_sum   <= '0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
      rd_data     <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N_ELEM; i++)
          bank[b][i] <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      // Read bank is always the one not being written; a swap is visible on the next read.
      rd_data     <= rd_in_range ? bank[~wbank][rd_addr] : '0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            bank[wbank][0] <= s_data;
            idx            <= AW'(1);
            prev           <= s_data;
            sum            <= SW'(s_data);
            err            <= 1'b0;
            err_pos        <= '0;
            busy           <= 1'b1;
            state          <= COLLECT;
          end
        end
        COLLECT: begin
          if (s_valid) begin
            bank[wbank][idx] <= s_data;
            idx              <= idx + 1'b1;
            prev             <= s_data;
            sum              <= sum_next;
            if (desc && !err) begin
              err     <= 1'b1;
              err_pos <= idx;
            end
            if (last) begin
              // Publish using the final sample's contribution directly.
              frame_done <= 1'b1;
              sort_err   <= err | desc;
              err_idx    <= err ? err_pos : (desc ? idx : '0);
              frame_sum  <= sum_next;
              frame_cnt  <= frame_cnt + 1'b1;
              wbank      <= ~wbank;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else begin
            frame_abort <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_stream_collector.sv
// Bench for sort_stream_collector: stream-level reference model with per-cycle
// comparison, directed frames with literal expectations, and randomized traffic.
module tb_sort_stream_collector;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int CW = 8;

  typedef logic [DW-1:0] frame_t [N];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [2:0]    rd_addr = '0;
  logic          frame_done, frame_abort, sort_err, busy;
  logic [2:0]    err_idx;
  logic [10:0]   frame_sum;
  logic [CW-1:0] frame_cnt;
  logic [DW-1:0] rd_data;

  sort_stream_collector #(.N_ELEM(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .frame_done(frame_done), .frame_abort(frame_abort), .sort_err(sort_err),
    .err_idx(err_idx), .frame_sum(frame_sum), .frame_cnt(frame_cnt), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: samples collected into a queue; a full queue becomes the published frame.
  logic [DW-1:0] q[$];
  logic [DW-1:0] pub [N];
  logic          e_done = 0, e_abort = 0, e_err = 0, e_busy = 0;
  int            e_eidx = 0, e_sum = 0;
  logic [CW-1:0] e_cnt = '0;
  logic [DW-1:0] e_rd = '0;
  bit            started = 0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < N; i++) pub[i] = '0;
      e_done = 0; e_abort = 0; e_err = 0; e_busy = 0;
      e_eidx = 0; e_sum = 0; e_cnt = '0; e_rd = '0;
    end else begin
      e_rd    = (int'(rd_addr) < N) ? pub[rd_addr] : '0;
      e_done  = 0;
      e_abort = 0;
      if (s_valid) begin
        q.push_back(s_data);
        if (q.size() == N) begin
          e_sum = 0; e_err = 0; e_eidx = 0;
          for (int i = 0; i < N; i++) begin
            e_sum += int'(q[i]);
            if (i > 0 && q[i] < q[i-1] && !e_err) begin
              e_err = 1; e_eidx = i;
            end
            pub[i] = q[i];
          end
          e_cnt  = e_cnt + 1'b1;
          e_done = 1;
          q.delete();
        end
      end else if (q.size() != 0) begin
        e_abort = 1;
        q.delete();
      end
      e_busy = (q.size() != 0);
    end
    started = 1;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("frame_done",  32'(frame_done),  32'(e_done));
      chk("frame_abort", 32'(frame_abort), 32'(e_abort));
      chk("sort_err",    32'(sort_err),    32'(e_err));
      chk("err_idx",     32'(err_idx),     e_eidx);
      chk("frame_sum",   32'(frame_sum),   e_sum);
      chk("frame_cnt",   32'(frame_cnt),   32'(e_cnt));
      chk("busy",        32'(busy),        32'(e_busy));
      chk("rd_data",     32'(rd_data),     32'(e_rd));
    end
  end

  task automatic drive_sample(input logic [DW-1:0] v);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = v;
    rd_addr = 3'($urandom_range(0, N-1));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    rd_addr = 3'($urandom_range(0, N-1));
  endtask

  task automatic send_frame(input frame_t f);
    for (int k = 0; k < N; k++) drive_sample(f[k]);
  endtask

  task automatic readback(input string nm, input frame_t exp);
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (i > 0) chk(nm, 32'(rd_data), 32'(exp[i-1]));
      if (i < N) rd_addr = 3'(i);
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    int v = $urandom_range(0, 60);
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 6) == 0) v = $urandom_range(0, 255);
      else v = (v + $urandom_range(0, 30) > 255) ? 255 : v + $urandom_range(0, 30);
      f[k] = 8'(v);
    end
    return f;
  endfunction

  initial begin
    frame_t f;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cnt",  32'(frame_cnt),  0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy),       0);
    chk("rst_rd",   32'(rd_data),    0);
    rst_n = 1'b1;
    idle_cycle();

    // Ascending frame
    send_frame('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    idle_cycle();
    chk("t1_done", 32'(frame_done), 1);
    chk("t1_err",  32'(sort_err),   0);
    chk("t1_sum",  32'(frame_sum),  36);
    chk("t1_cnt",  32'(frame_cnt),  1);
    readback("t1_rd", '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});

    // Descending pair at index 2, equal neighbours elsewhere
    send_frame('{8'd3, 8'd5, 8'd4, 8'd6, 8'd6, 8'd7, 8'd8, 8'd9});
    idle_cycle();
    chk("t2_err",  32'(sort_err),  1);
    chk("t2_idx",  32'(err_idx),   2);
    chk("t2_sum",  32'(frame_sum), 48);

    // Partial frame aborted by an s_valid gap
    for (int k = 0; k < 5; k++) drive_sample(8'(10 + k));
    idle_cycle();
    idle_cycle();
    chk("t3_abort", 32'(frame_abort), 1);
    chk("t3_done",  32'(frame_done),  0);
    chk("t3_cnt",   32'(frame_cnt),   2);
    chk("t3_sum",   32'(frame_sum),   48);
    readback("t3_rd", '{8'd3, 8'd5, 8'd4, 8'd6, 8'd6, 8'd7, 8'd8, 8'd9});

    // Two frames back-to-back; read old bank while the second is captured
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 8) chk("t4_done1", 32'(frame_done), 1);
      if (i > 8) begin
        chk("t4_nodone", 32'(frame_done), 0);
        chk("t4_rd_mid", 32'(rd_data), i - 9);
      end
      s_valid = 1'b1;
      s_data  = 8'(i);
      rd_addr = (i >= 8) ? 3'(i - 8) : 3'($urandom_range(0, N-1));
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("t4_done2", 32'(frame_done), 1);
    chk("t4_rd_last_old", 32'(rd_data), 7);
    readback("t4_rd_new", '{8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15});

    // Saturated samples and frame counter wrap
    send_frame('{default: 8'd255});
    idle_cycle();
    chk("t5_err", 32'(sort_err),  0);
    chk("t5_sum", 32'(frame_sum), 2040);
    chk("t5_cnt", 32'(frame_cnt), 5);
    for (int j = 0; j < (1 << CW) - 5; j++) send_frame(rand_frame());
    idle_cycle();
    chk("t5_wrap_done", 32'(frame_done), 1);
    chk("t5_wrap_cnt",  32'(frame_cnt),  0);

    // Reset in the middle of a frame
    for (int k = 0; k < 4; k++) drive_sample(8'(40 + k));
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_rst_cnt",  32'(frame_cnt), 0);
    chk("t6_rst_busy", 32'(busy),      0);
    send_frame('{8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27});
    idle_cycle();
    chk("t6_done",  32'(frame_done),  1);
    chk("t6_abort", 32'(frame_abort), 0);
    chk("t6_cnt",   32'(frame_cnt),   1);
    readback("t6_rd", '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27});

    // Random traffic: bursts of arbitrary length with random gaps
    for (int j = 0; j < 60; j++) begin
      f = rand_frame();
      for (int k = 0; k < int'($urandom_range(1, N)); k++) drive_sample(f[k]);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    repeat (3) idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
